// File: rtl/mod_74x_pkg.sv
// rtl/mod_74x_pkg.sv - gate function codes, BIST state encoding and the shared per-bit gate function
package mod_74x_pkg;

  localparam logic [2:0] MODE_AND    = 3'd0;
  localparam logic [2:0] MODE_NAND   = 3'd1;
  localparam logic [2:0] MODE_OR     = 3'd2;
  localparam logic [2:0] MODE_NOR    = 3'd3;
  localparam logic [2:0] MODE_XOR    = 3'd4;
  localparam logic [2:0] MODE_XNOR   = 3'd5;
  localparam logic [2:0] MODE_PASS_A = 3'd6;
  localparam logic [2:0] MODE_PASS_B = 3'd7;

  localparam int BIST_VECTORS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  function automatic logic gate_eval(input logic [2:0] mode, input logic a, input logic b);
    logic y;
    case (mode)
      MODE_AND:    y = a & b;
      MODE_NAND:   y = ~(a & b);
      MODE_OR:     y = a | b;
      MODE_NOR:    y = ~(a | b);
      MODE_XOR:    y = a ^ b;
      MODE_XNOR:   y = ~(a ^ b);
      MODE_PASS_A: y = a;
      default:     y = b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mod_74x_pipe_stage.sv
// rtl/mod_74x_pipe_stage.sv - one pipeline register stage with enable; data loads only with a valid word
module mod_74x_pipe_stage #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Bubbles leave data untouched so the last stage keeps showing the last real word.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en_i) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mod_74x08_n_reg.sv
// rtl/mod_74x08_n_reg.sv - registered gate bank with selectable function, flow control and truth-table self-test
module mod_74x08_n_reg
  import mod_74x_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int PIPE     = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [2:0]          MODE,
  input  logic [CHANNELS-1:0] A,
  input  logic [CHANNELS-1:0] B,
  input  logic                IN_VALID,
  output logic                IN_READY,
  output logic [CHANNELS-1:0] Y,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  input  logic                BIST_START,
  output logic                BIST_BUSY,
  output logic                BIST_DONE,
  output logic [CHANNELS-1:0] BIST_FAIL
);

  // Stage word: {bist tag, vector index, result}; the tag never reaches the output stage.
  localparam int DW  = CHANNELS + 3;
  localparam int TAG = CHANNELS + 2;

  bist_state_e         state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          bist_mode_q, bist_mode_d;
  logic [CHANNELS-1:0] fail_q, fail_d;

  logic                vld   [PIPE+1];
  logic [DW-1:0]       sdata [PIPE];
  logic                s0_valid;
  logic [DW-1:0]       s0_data;
  logic                busy, stall, en, pipe_empty;
  logic                cmp_valid, last_valid_in;
  logic [1:0]          run_idx, cmp_idx;
  logic [CHANNELS-1:0] word_res, bist_res, cmp_exp, cmp_res;

  assign busy      = (state_q != ST_IDLE);
  assign stall     = OUT_VALID & ~OUT_READY & ~busy;
  assign en        = ~stall;
  assign IN_READY  = ~stall & ~busy;
  assign OUT_VALID = vld[PIPE];
  assign BIST_BUSY = busy;
  assign BIST_DONE = (state_q == ST_DONE);
  assign BIST_FAIL = fail_q;

  assign run_idx   = cnt_q[1:0];
  assign cmp_valid = vld[PIPE-1] & sdata[PIPE-1][TAG];
  assign cmp_idx   = sdata[PIPE-1][CHANNELS+1:CHANNELS];
  assign cmp_res   = sdata[PIPE-1][CHANNELS-1:0];

  // Vector index k drives A=~k[0], B=~k[1]: 11, 01, 10, 00 for k = 0..3.
  always_comb begin
    word_res = '0;
    bist_res = '0;
    cmp_exp  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      word_res[i] = gate_eval(MODE, A[i], B[i]);
      bist_res[i] = gate_eval(bist_mode_q, ~run_idx[0], ~run_idx[1]);
      cmp_exp[i]  = gate_eval(bist_mode_q, ~cmp_idx[0], ~cmp_idx[1]);
    end
  end

  always_comb begin
    s0_valid = IN_VALID & IN_READY;
    s0_data  = {1'b0, 2'b00, word_res};
    if (state_q == ST_RUN) begin
      s0_valid = 1'b1;
      s0_data  = {1'b1, run_idx, bist_res};
    end
  end

  assign vld[0]   = s0_valid;
  assign sdata[0] = s0_data;

  always_comb begin
    pipe_empty = 1'b1;
    for (int k = 1; k <= PIPE; k++) begin
      if (vld[k]) pipe_empty = 1'b0;
    end
  end

  // BIST words are compared as they enter the output stage and enter it as bubbles.
  assign last_valid_in = vld[PIPE-1] & ~sdata[PIPE-1][TAG];

  for (genvar k = 0; k < PIPE; k++) begin : g_stage
    if (k < PIPE - 1) begin : g_mid
      mod_74x_pipe_stage #(.W(DW)) u_stage (
        .clk_i   (CLK),
        .rst_i   (RST),
        .en_i    (en),
        .valid_i (vld[k]),
        .data_i  (sdata[k]),
        .valid_o (vld[k+1]),
        .data_o  (sdata[k+1])
      );
    end else begin : g_last
      mod_74x_pipe_stage #(.W(CHANNELS)) u_stage (
        .clk_i   (CLK),
        .rst_i   (RST),
        .en_i    (en),
        .valid_i (last_valid_in),
        .data_i  (sdata[k][CHANNELS-1:0]),
        .valid_o (vld[k+1]),
        .data_o  (Y)
      );
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bist_mode_d = bist_mode_q;
    fail_d      = fail_q;
    if (cmp_valid) fail_d = fail_q | (cmp_res ^ cmp_exp);
    case (state_q)
      ST_IDLE: begin
        if (BIST_START && pipe_empty) begin
          state_d     = ST_RUN;
          cnt_d       = 3'd0;
          bist_mode_d = MODE;
          fail_d      = '0;
        end
      end
      ST_RUN: begin
        if (cnt_q == 3'(BIST_VECTORS - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 3'(PIPE)) begin
          state_d = ST_DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      bist_mode_q <= 3'd0;
      fail_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bist_mode_q <= bist_mode_d;
      fail_q      <= fail_d;
    end
  end

endmodule

// File: tb/tb_mod_74x08_n_reg.sv
// tb/tb_mod_74x08_n_reg.sv - scoreboard bench for the registered gate bank
module tb_mod_74x08_n_reg;

  localparam int CH   = 4;
  localparam int PIPE = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [2:0]    MODE = 3'd0;
  logic [CH-1:0] A = '0, B = '0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [CH-1:0] Y;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b1;
  logic          BIST_START = 1'b0;
  logic          BIST_BUSY, BIST_DONE;
  logic [CH-1:0] BIST_FAIL;

  mod_74x08_n_reg #(.CHANNELS(CH), .PIPE(PIPE)) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .A(A), .B(B),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .Y(Y), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .BIST_START(BIST_START), .BIST_BUSY(BIST_BUSY),
    .BIST_DONE(BIST_DONE), .BIST_FAIL(BIST_FAIL)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rdy_mode = 0;

  always @(posedge CLK) cyc++;

  typedef struct {
    logic [CH-1:0] y;
    bit            chk_lat;
    int            acc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Truth table per mode, indexed by {a,b}.
  logic [3:0] tt [8] = '{4'b1000, 4'b0111, 4'b1110, 4'b0001, 4'b0110, 4'b1001, 4'b1100, 4'b1010};

  function automatic logic [CH-1:0] ref_gate(input int m, input logic [CH-1:0] a, input logic [CH-1:0] b);
    logic [CH-1:0] r;
    logic [3:0]    row;
    row = tt[m];
    for (int i = 0; i < CH; i++) r[i] = row[{a[i], b[i]}];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (rdy_mode == 0)      OUT_READY = 1'b1;
    else if (rdy_mode == 1) OUT_READY = 1'($urandom_range(0, 1));
    else                    OUT_READY = 1'b0;
  end

  logic          prev_stall = 1'b0;
  logic [CH-1:0] prev_y = '0;
  bit            ov_in_bist = 0;

  always @(negedge CLK) begin
    #2;
    if (RST) begin
      prev_stall = 1'b0;
    end else begin
      if (OUT_VALID && BIST_BUSY) ov_in_bist = 1;
      if (prev_stall) begin
        check("stall_hold_valid", 32'(OUT_VALID), 32'd1);
        check("stall_hold_y", 32'(Y), 32'(prev_y));
      end
      if (OUT_VALID && !OUT_READY && !BIST_BUSY) check("stall_in_ready", 32'(IN_READY), 32'd0);
      if (OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("y", 32'(Y), 32'(mon_e.y));
          if (mon_e.chk_lat) check("latency", 32'(cyc - mon_e.acc), 32'(PIPE));
        end
      end
      prev_stall = OUT_VALID && !OUT_READY;
      prev_y     = Y;
    end
  end

  task automatic send(input logic [2:0] m, input logic [CH-1:0] a, input logic [CH-1:0] b,
                      input logic [CH-1:0] y_exp, input bit lat);
    int   w;
    exp_t e;
    w = 0;
    @(negedge CLK);
    MODE = m; A = a; B = b; IN_VALID = 1'b1;
    #1;
    while (!IN_READY && w < 100) begin
      @(negedge CLK);
      #1;
      w++;
    end
    if (!IN_READY) begin
      check("send_timeout", 32'd0, 32'd1);
      IN_VALID = 1'b0;
    end else begin
      e.y = y_exp; e.chk_lat = lat; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() > 0 && w < 300) begin
      @(negedge CLK);
      w++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(negedge CLK);
  endtask

  logic [CH-1:0] t3_y [8] = '{4'b1000, 4'b0111, 4'b1110, 4'b0001, 4'b0110, 4'b1001, 4'b1010, 4'b1100};

  initial begin
    logic [2:0]    m;
    logic [CH-1:0] a, b;
    int            acc, w;
    bit            done_seen;

    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_y", 32'(Y), 32'd0);
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_in_ready", 32'(IN_READY), 32'd1);
    check("rst_bist_busy", 32'(BIST_BUSY), 32'd0);
    check("rst_bist_done", 32'(BIST_DONE), 32'd0);
    check("rst_bist_fail", 32'(BIST_FAIL), 32'd0);

    send(3'd0, 4'b1011, 4'b1101, 4'b1001, 1);
    idle();
    wait_drain();

    for (int i = 0; i < 8; i++) send(3'(i), 4'b1010, 4'b1100, t3_y[i], 1);
    idle();
    wait_drain();

    rdy_mode = 2;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          m = 3'($urandom_range(0, 7)); a = 4'($urandom); b = 4'($urandom);
          send(m, a, b, ref_gate(int'(m), a, b), 0);
        end
        idle();
      end
      begin
        w = 0;
        while (!OUT_VALID && w < 50) begin
          @(negedge CLK);
          #3;
          w++;
        end
        check("stall_reached", 32'(OUT_VALID), 32'd1);
        repeat (3) @(negedge CLK);
        rdy_mode = 0;
      end
    join
    wait_drain();

    for (int i = 0; i < 20; i++) begin
      m = 3'($urandom_range(0, 7)); a = 4'($urandom); b = 4'($urandom);
      send(m, a, b, ref_gate(int'(m), a, b), 1);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    wait_drain();

    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      m = 3'($urandom_range(0, 7)); a = 4'($urandom); b = 4'($urandom);
      send(m, a, b, ref_gate(int'(m), a, b), 0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    rdy_mode = 0;
    wait_drain();

    ov_in_bist = 0;
    rdy_mode = 2;
    @(negedge CLK);
    MODE = 3'd4; BIST_START = 1'b1;
    acc = cyc;
    @(negedge CLK);
    BIST_START = 1'b0; MODE = 3'd0;
    #1;
    check("bist_busy", 32'(BIST_BUSY), 32'd1);
    check("bist_in_ready", 32'(IN_READY), 32'd0);
    w = 0;
    while (!BIST_DONE && w < 30) begin
      @(negedge CLK);
      #1;
      w++;
    end
    check("bist_done_time", 32'(cyc - (acc + 1)), 32'(PIPE + 5));
    check("bist_fail", 32'(BIST_FAIL), 32'd0);
    @(negedge CLK);
    #1;
    check("bist_done_pulse", 32'(BIST_DONE), 32'd0);
    check("bist_busy_end", 32'(BIST_BUSY), 32'd0);
    check("bist_no_out_valid", 32'(ov_in_bist), 32'd0);
    rdy_mode = 0;

    send(3'd0, 4'b1111, 4'b1111, 4'b1111, 1);
    @(negedge CLK);
    IN_VALID = 1'b0; BIST_START = 1'b1;
    @(negedge CLK);
    BIST_START = 1'b0;
    #1;
    check("bist_ignored_inflight", 32'(BIST_BUSY), 32'd0);
    wait_drain();

    @(negedge CLK);
    BIST_START = 1'b1;
    @(negedge CLK);
    BIST_START = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("abort_busy", 32'(BIST_BUSY), 32'd0);
    check("abort_out_valid", 32'(OUT_VALID), 32'd0);
    check("abort_y", 32'(Y), 32'd0);
    done_seen = 0;
    repeat (15) begin
      @(negedge CLK);
      #1;
      if (BIST_DONE) done_seen = 1;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    send(3'd2, 4'b0101, 4'b0011, 4'b0111, 1);
    idle();
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
